// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the SIPO receiver slice.
package sipo_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 8;

  // Reset contents of the storage register (sliced to WIDTH by users).
  localparam logic [31:0] SIPO_STORE_RST = 32'h0;

  // Bit-counter width; a 2-bit frame still needs a 1-bit counter.
  function automatic int sipo_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register with frame bit counter and completion strobe.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser,
  input  logic             sh_en,
  input  logic             clr,
  output logic [WIDTH-1:0] sreg,
  output logic             done,
  output logic             qh_s
);

  localparam int CW = sipo_cnt_width(WIDTH);

  logic [CW-1:0] cnt;

  // A clear on the same edge discards the shift, so no completion either.
  assign done = sh_en && !clr && (cnt == CW'(WIDTH - 1));
  assign qh_s = sreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (sh_en) begin
      sreg <= {sreg[WIDTH-2:0], ser};
      cnt  <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_shiftreg.sv
// SIPO receiver: shift core plus storage latch, FULL pulse, OVERRUN flag, OE gate.
// Optional build macro SIPO_AUTOLATCH_EN loads storage on every completed frame.
module sipo_shiftreg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SER,
  input  logic             SH_EN,
  input  logic             CLR,
  input  logic             LATCH,
  input  logic             OE,
  output logic [WIDTH-1:0] Q,
  output logic             QH_S,
  output logic             FULL,
  output logic             OVERRUN
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] storage;
  logic             done;
  logic             pending;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk   (CLK),
    .rst   (RST),
    .ser   (SER),
    .sh_en (SH_EN),
    .clr   (CLR),
    .sreg  (sreg),
    .done  (done),
    .qh_s  (QH_S)
  );

  // LATCH captures sreg as it stood before this edge's shift or clear.
  always_ff @(posedge CLK) begin
    if (RST)
      storage <= SIPO_STORE_RST[WIDTH-1:0];
`ifdef SIPO_AUTOLATCH_EN
    else if (done)
      storage <= {sreg[WIDTH-2:0], SER};
`endif
    else if (LATCH)
      storage <= sreg;
  end

  // A completion on the latching edge leaves a fresh unlatched frame behind.
  always_ff @(posedge CLK) begin
    if (RST || CLR)
      pending <= 1'b0;
`ifndef SIPO_AUTOLATCH_EN
    else if (done)
      pending <= 1'b1;
`endif
    else if (LATCH)
      pending <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST || CLR)
      OVERRUN <= 1'b0;
    else if (done && pending)
      OVERRUN <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      FULL <= 1'b0;
    else
      FULL <= done;
  end

  assign Q = OE ? storage : '0;

endmodule

// File: tb/tb_sipo_shiftreg.sv
// Directed bench for sipo_shiftreg (WIDTH=8); honours SIPO_AUTOLATCH_EN.
module tb_sipo_shiftreg;

  logic       CLK = 1'b0;
  logic       RST, SER, SH_EN, CLR, LATCH, OE;
  logic [7:0] Q;
  logic       QH_S, FULL, OVERRUN;

  int vectors    = 0;
  int miscompares = 0;

  sipo_shiftreg #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SER     (SER),
    .SH_EN   (SH_EN),
    .CLR     (CLR),
    .LATCH   (LATCH),
    .OE      (OE),
    .Q       (Q),
    .QH_S    (QH_S),
    .FULL    (FULL),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift n bits of b MSB-first with SH_EN high, one per edge.
  task automatic shift_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      SER   = b[7-i];
      SH_EN = 1'b1;
      step();
    end
    SH_EN = 1'b0;
    SER   = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int         full_cnt;

    RST = 1'b1; SER = 1'b0; SH_EN = 1'b0; CLR = 1'b0; LATCH = 1'b0; OE = 1'b1;
    step();
    step();
    check("rst_q", 32'(Q), 32'h0);
    check("rst_full", 32'(FULL), 32'h0);
    check("rst_overrun", 32'(OVERRUN), 32'h0);
    check("rst_qhs", 32'(QH_S), 32'h0);
    RST = 1'b0;
    step();

`ifdef SIPO_AUTOLATCH_EN
    // Autolatch: Q shows the word in the FULL cycle, no OVERRUN ever.
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      SER = pat[7-i]; SH_EN = 1'b1;
      step();
      check("al_full", 32'(FULL), (i == 7) ? 32'h1 : 32'h0);
    end
    SH_EN = 1'b0;
    check("al_q", 32'(Q), 32'h5A);
    shift_bits(8'hC3, 8);
    check("al_q2", 32'(Q), 32'hC3);
    shift_bits(8'h96, 8);
    check("al_q3", 32'(Q), 32'h96);
    check("al_overrun", 32'(OVERRUN), 32'h0);
    // Reset mid-frame discards the partial word.
    shift_bits(8'hF0, 4);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("al_rst_q", 32'(Q), 32'h0);
    check("al_rst_full", 32'(FULL), 32'h0);
    full_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      SER = 1'b1; SH_EN = 1'b1;
      step();
      full_cnt += FULL;
    end
    SH_EN = 1'b0;
    check("al_rst_cnt", 32'(full_cnt), 32'h0);
`else
    // Frame 8'hB2, FULL exactly one cycle after the 8th shift.
    pat = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      SER = pat[7-i]; SH_EN = 1'b1;
      step();
      check("b2_full", 32'(FULL), (i == 7) ? 32'h1 : 32'h0);
    end
    SH_EN = 1'b0; LATCH = 1'b1;
    step();
    LATCH = 1'b0;
    check("b2_full_drop", 32'(FULL), 32'h0);
    check("b2_q", 32'(Q), 32'hB2);
    check("b2_overrun", 32'(OVERRUN), 32'h0);

    // Two back-to-back unlatched frames raise OVERRUN.
    for (int i = 0; i < 16; i++) begin
      pat = (i < 8) ? 8'hA5 : 8'h3C;
      SER = pat[7-(i%8)]; SH_EN = 1'b1;
      step();
      check("b2b_full", 32'(FULL), (i == 7 || i == 15) ? 32'h1 : 32'h0);
      if (i == 7) check("b2b_ovr_first", 32'(OVERRUN), 32'h0);
    end
    SH_EN = 1'b0;
    check("b2b_overrun", 32'(OVERRUN), 32'h1);
    check("b2b_q_held", 32'(Q), 32'hB2);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_overrun", 32'(OVERRUN), 32'h0);
    check("clr_q_held", 32'(Q), 32'hB2);

    // CLR with SH_EN discards the partial frame and the shift.
    shift_bits(8'hFF, 5);
    SER = 1'b1; SH_EN = 1'b1; CLR = 1'b1;
    step();
    CLR = 1'b0; SH_EN = 1'b0;
    check("clrsh_full", 32'(FULL), 32'h0);
    check("clrsh_qhs", 32'(QH_S), 32'h0);
    for (int i = 0; i < 8; i++) begin
      SER = 1'b1; SH_EN = 1'b1;
      step();
      check("ff_full", 32'(FULL), (i == 7) ? 32'h1 : 32'h0);
    end
    SH_EN = 1'b0; LATCH = 1'b1;
    step();
    LATCH = 1'b0;
    check("ff_q", 32'(Q), 32'hFF);

    // OE gates Q combinationally.
    shift_bits(8'h81, 8);
    LATCH = 1'b1;
    step();
    LATCH = 1'b0;
    OE = 1'b0;
    #1;
    check("oe_off_q", 32'(Q), 32'h0);
    OE = 1'b1;
    #1;
    check("oe_on_q", 32'(Q), 32'h81);
    check("oe_overrun", 32'(OVERRUN), 32'h0);

    // Cascade output walks the frame out MSB-first.
    pat = 8'hC3;
    shift_bits(pat, 8);
    check("qhs_0", 32'(QH_S), 32'(pat[7]));
    for (int k = 1; k < 8; k++) begin
      SER = 1'b0; SH_EN = 1'b1;
      step();
      check("qhs_k", 32'(QH_S), 32'(pat[7-k]));
    end
    SER = 1'b0; SH_EN = 1'b1;
    step();
    SH_EN = 1'b0;
    check("qhs_end", 32'(QH_S), 32'h0);
    check("qhs_full", 32'(FULL), 32'h1);
    check("qhs_overrun", 32'(OVERRUN), 32'h1);

    // Latch coincident with a shift takes the pre-shift word.
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    shift_bits(8'h96, 8);
    SER = 1'b1; SH_EN = 1'b1; LATCH = 1'b1;
    step();
    SH_EN = 1'b0; LATCH = 1'b0;
    check("coin_q", 32'(Q), 32'h96);

    // Latch coincident with the completing shift: pending survives.
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    shift_bits(8'h5A, 7);
    SER = 1'b0; SH_EN = 1'b1; LATCH = 1'b1;
    step();
    SH_EN = 1'b0; LATCH = 1'b0;
    check("coin_done_q", 32'(Q), 32'h2D);
    check("coin_done_full", 32'(FULL), 32'h1);
    shift_bits(8'h00, 8);
    check("coin_done_ovr", 32'(OVERRUN), 32'h1);

    // Reset mid-frame: no FULL, counter restarts.
    shift_bits(8'hF0, 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mrst_q", 32'(Q), 32'h0);
    check("mrst_full", 32'(FULL), 32'h0);
    check("mrst_overrun", 32'(OVERRUN), 32'h0);
    full_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      SER = 1'b1; SH_EN = 1'b1;
      step();
      full_cnt += FULL;
    end
    SH_EN = 1'b0;
    check("mrst_cnt", 32'(full_cnt), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_shiftreg.md
# sipo_shiftreg

Serial-in/parallel-out receiver shift register with a storage latch. It is the receive end of the serial link driven by the parallel-load shift register on the other board. It shifts SER in MSB-first, counts bits per frame, and flags frame completion. It presents the latched word on a parallel bus and also provides a cascade serial output for daisy-chaining.

## Interface
- WIDTH, 8, frame length in bits; legal range 2..32
- CLK  input  1  system clock; all state changes on the rising edge
- RST  input  1  synchronous, active-high reset
- SER  input  1  serial data in; sampled when SH_EN=1
- SH_EN  input  1  shift enable; one bit is accepted per CLK edge while high
- CLR  input  1  synchronous clear of the shift register, bit counter and OVERRUN; storage is untouched
- LATCH  input  1  copies the shift register into storage on this edge
- OE  input  1  output enable for Q
- Q  output  WIDTH  storage contents when OE=1, else all zeros (combinational gate on OE)
- QH_S  output  1  cascade output, equal to shift register bit WIDTH-1
- FULL  output  1  one-cycle pulse marking frame completion
- OVERRUN  output  1  sticky flag: a frame completed while the previous one was still unlatched

## Operation
- Shift on SH_EN=1: sreg <= {sreg[WIDTH-2:0], SER}. The first received bit ends in Q[WIDTH-1] after WIDTH shifts.
- Bit counter: cnt runs 0..WIDTH-1 and increments per shift. On a shift with cnt=WIDTH-1, the frame completes and cnt wraps to 0.
- FULL: registered, high for exactly the one cycle after the completing edge.
- Storage:
  - On LATCH=1, storage <= sreg as it was before this edge's shift.
  - When LATCH and SH_EN coincide, storage takes the pre-shift contents.
- Pending flag (internal):
  - Set on frame completion.
  - Cleared by LATCH, CLR or RST.
  - If LATCH coincides with a completing shift, the latch takes the pre-shift word and pending ends at 1.
- OVERRUN: set on a frame completion while pending=1; cleared only by CLR or RST.
- Priority per edge: RST > CLR > SH_EN. A CLR that coincides with SH_EN discards the shift, and FULL stays low. LATCH is evaluated in parallel with CLR and uses pre-clear sreg.
- Reset values: sreg=0, cnt=0, storage=0, pending=0, FULL=0, OVERRUN=0, QH_S=0, Q=0.
- Reset mid-frame: a partial frame is discarded and no FULL is issued.

## Timing
- Shift latency: a bit sampled at edge n appears at sreg[0] after edge n, and at QH_S after edge n+WIDTH-1.
- FULL is high in the cycle following the WIDTH-th shift edge.
- Continuous SH_EN=1 gives one FULL every WIDTH cycles with no gap cycles; back-to-back frames are supported.
- Q changes one edge after LATCH, or combinationally with OE.
- SH_EN=0 holds all state; cnt does not advance.

## Configuration
- SIPO_AUTOLATCH_EN defined:
  - On the completing edge, storage <= {sreg[WIDTH-2:0], SER}, the full new word. Q updates in the same cycle FULL rises.
  - Pending is never set, so OVERRUN stays 0.
  - External LATCH is still honoured; on a coincident edge, autolatch wins.
- SIPO_AUTOLATCH_EN undefined: storage loads only on LATCH.

## Structure
- Shared package sipo_pkg holds:
  - The default WIDTH constant.
  - The counter-width function (clog2 of WIDTH).
  - The reset value constant for storage.
- Sub-module sipo_shift_core holds sreg, cnt, the completion strobe and QH_S.
- The top level adds storage, pending/OVERRUN, FULL registration and OE gating.

## Test plan
- Reset then shift 8 bits 1,0,1,1,0,0,1,0, then LATCH, OE=1:
  - Q=8'hB2.
  - FULL pulses once, one cycle after the 8th shift.
  - OVERRUN=0.
- Continuous SH_EN for 16 cycles with no LATCH, sending 8'hA5 then 8'h3C:
  - FULL pulses at cycles 9 and 17.
  - OVERRUN=1 after the second completion.
  - CLR clears it to 0.
- Shift 5 bits then CLR asserted together with SH_EN: sreg=0, cnt=0, no FULL. The next 8 shifts of 8'hFF give FULL and Q=8'hFF after LATCH.
- Shift 8'h81, then OE=0: Q=0 while storage holds 8'h81. OE=1 restores Q=8'h81 with no clock edge needed.
- QH_S cascade: shift 8'hC3 then 8 more zeros. QH_S emits 1,1,0,0,0,0,1,1 on successive edges after the first frame.
- With SIPO_AUTOLATCH_EN: shift 8'h5A with no LATCH. Q=8'h5A in the FULL cycle; repeated frames never set OVERRUN. RST mid-frame (4 bits in) gives Q=0 and no FULL.
